// File: rtl/dmem_responder.sv
// dmem_responder: load/store target with configurable wait states and a one-cycle response.
// Commit (store write, response capture) happens on the edge that enters RESP.
module dmem_responder #(
   parameter int WORD_SIZE   = 32,
   parameter int ADDR_SIZE   = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [ADDR_SIZE-1:0] req_addr,
   input  logic [WORD_SIZE-1:0] req_wdata,
   input  logic [1:0]           req_size,
   input  logic                 req_sign,
   output logic                 resp_valid,
   output logic [WORD_SIZE-1:0] resp_rdata,
   output logic                 resp_err,
   output logic                 busy
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state, nxt;
   logic [3:0] cnt;
   logic l_write, l_sign;
   logic [ADDR_SIZE-1:0] l_addr;
   logic [WORD_SIZE-1:0] l_wdata;
   logic [1:0] l_size;
   logic [WORD_SIZE-1:0] mem [2**(ADDR_SIZE-2)];
   logic op_write, op_sign, err, commit;
   logic [ADDR_SIZE-1:0] op_addr;
   logic [WORD_SIZE-1:0] op_wdata, word, ld, wd;
   logic [1:0] op_size;
   logic [7:0] b;
   logic [15:0] h;
   logic [3:0] be;
   // With zero wait states the commit edge is the accept edge, so use live inputs in IDLE.
   always_comb begin
      req_ready = state == IDLE;
      busy      = !req_ready;
      nxt       = state == IDLE ? (req_valid ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE) :
                  state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : IDLE;
      commit    = rst && nxt == RESP;
      op_write  = req_ready ? req_write : l_write;
      op_addr   = req_ready ? req_addr  : l_addr;
      op_wdata  = req_ready ? req_wdata : l_wdata;
      op_size   = req_ready ? req_size  : l_size;
      op_sign   = req_ready ? req_sign  : l_sign;
      err       = op_size == 2'b11 || (op_size == 2'b01 && op_addr[0]) ||
                  (op_size == 2'b10 && op_addr[1:0] != 2'b00);
      word      = mem[op_addr[ADDR_SIZE-1:2]];
      b         = word[{op_addr[1:0], 3'b000} +: 8];
      h         = op_addr[1] ? word[31:16] : word[15:0];
      ld        = op_size == 2'b10 ? word :
                  op_size == 2'b01 ? {{(WORD_SIZE-16){op_sign & h[15]}}, h} :
                                     {{(WORD_SIZE-8){op_sign & b[7]}}, b};
      be        = op_size == 2'b00 ? 4'b0001 << op_addr[1:0] :
                  op_size == 2'b01 ? (op_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wd        = op_size == 2'b00 ? {4{op_wdata[7:0]}} :
                  op_size == 2'b01 ? {2{op_wdata[15:0]}} : op_wdata;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         l_write    <= 1'b0;
         l_addr     <= '0;
         l_wdata    <= '0;
         l_size     <= '0;
         l_sign     <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         state      <= nxt;
         cnt        <= state == IDLE && req_valid ? 4'(WAIT_CYCLES) : state == WAIT ? cnt - 4'd1 : cnt;
         if (state == IDLE && req_valid) begin
            l_write <= req_write;
            l_addr  <= req_addr;
            l_wdata <= req_wdata;
            l_size  <= req_size;
            l_sign  <= req_sign;
         end
         resp_valid <= commit;
         resp_rdata <= commit && !op_write && !err ? ld : '0;
         resp_err   <= commit && err;
      end
   end
   always_ff @(posedge clk)
      if (commit && op_write && !err)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[op_addr[ADDR_SIZE-1:2]][8*i +: 8] <= wd[8*i +: 8];
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target side of the core's load/store request interface, driven by the MEM stage.
- Accepts one byte/half/word load or store at a time through a valid/ready request handshake.
- Models a configurable number of wait states, then returns a single-cycle response.
- Response carries sign- or zero-extended load data and a misalignment error flag; the core stalls on busy.

Parameters:
- WORD_SIZE, 32, data width in bits; only 32 is supported.
- ADDR_SIZE, 10, byte-address width; storage depth is 2^(ADDR_SIZE-2) words.
- WAIT_CYCLES, 1, wait states between accept and response; legal range 0..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_SIZE  byte address.
- req_wdata  input  WORD_SIZE  store data, LSB-justified.
- req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- req_sign  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  WORD_SIZE  load result; 0 for stores and errors.
- resp_err  output  1  misaligned or illegal access; qualified by resp_valid.
- busy  output  1  request in flight (state != IDLE).

Behaviour:
- Reset (rst low, asynchronous): state IDLE, wait counter 0, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, busy 0.
- Storage array is not reset.
- States: IDLE, WAIT, RESP. req_ready = (state == IDLE); busy = !req_ready.
- IDLE: on the edge with req_valid && req_ready, latch write, addr, wdata, size and sign. Request inputs are ignored at all other times.
  - WAIT_CYCLES > 0: go to WAIT with counter = WAIT_CYCLES.
  - WAIT_CYCLES = 0: go directly to RESP.
- WAIT: counter decrements each edge. When counter == 1, next state is RESP.
- Commit point is the edge entering RESP:
  - Store data is written into the array.
  - resp_rdata and resp_err are registered.
- Timing: an accept on edge E gives resp_valid high in the cycle after edge E+WAIT_CYCLES, i.e. latency WAIT_CYCLES+1 cycles.
- RESP lasts exactly one cycle, then returns to IDLE. There is no response backpressure.
- resp_valid, resp_rdata and resp_err return to 0 in IDLE/WAIT.
- Throughput: one request per WAIT_CYCLES+2 cycles when req_valid is held high.
- Alignment: error if size 01 with addr[0] = 1, size 10 with addr[1:0] != 0, or size 11.
  - On error: no array write, resp_rdata = 0, resp_err = 1.
- Word index is addr[ADDR_SIZE-1:2]. Lane select uses addr[1:0].
- Store lanes:
  - Byte: wdata[7:0] goes to byte lane addr[1:0].
  - Half: wdata[15:0] goes to lanes {addr[1],0} and {addr[1],1}.
  - Word: full word.
  - All other lanes are unchanged (read-modify-write or per-byte enables).
- Load: extract the lane (same lane mapping as stores). Bit 7/15 is replicated when req_sign = 1, zero-filled otherwise. Word loads ignore req_sign.
- Store response: resp_rdata = 0, resp_err = 0 unless misaligned.
- Reset mid-operation: the in-flight request is discarded. A store aborted before reaching RESP never modifies the array.

Test Plan:
- Latency/word round trip (WAIT_CYCLES=2): store word 0xDEADBEEF to 0x010, then load word from 0x010 -> resp_valid exactly 3 cycles after each accept, one cycle wide; load returns 0xDEADBEEF, resp_err 0.
- Byte lanes: store word 0x00000000 to 0x010, then store byte 0x80 to 0x013.
  - Signed byte load 0x013 -> 0xFFFFFF80.
  - Unsigned byte load 0x013 -> 0x00000080.
  - Word load 0x010 -> 0x80000000.
- Halves: store word 0x80017FFF to 0x010.
  - Signed half load 0x012 -> 0xFFFF8001.
  - Signed half load 0x010 -> 0x00007FFF.
  - Unsigned half load 0x012 -> 0x00008001.
- Misalignment: store word 0x12345678 to 0x011 -> resp_err 1, resp_rdata 0; word load 0x010 still 0x80017FFF. Half load at 0x013 -> resp_err 1. Size 11 -> resp_err 1.
- Reset mid-op: accept store 0xFFFFFFFF to 0x010, assert rst during WAIT -> all outputs at reset values immediately, req_ready 1 after release; word load 0x010 returns the prior value.
- Back-to-back (WAIT_CYCLES=0): req_valid held high with three loads -> accepts every 2nd cycle, resp_valid in the cycle after each accept, busy high between accepts.
